// File: rtl/line_memory.sv
// Line-wide data memory with a fixed request-to-ack latency, placed behind the data cache.
// Optional LINE_MEMORY_ADDR_CHECK_EN: out-of-range line indices read zero, never write, and set sticky err_o.
module line_memory #(
  parameter int LINE_W  = 256,
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 512,
  parameter int LATENCY = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              write_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [LINE_W-1:0] data_i,
  output logic [LINE_W-1:0] data_o,
  output logic              ack_o,
  output logic              err_o
);

  localparam int IDX_W      = $clog2(DEPTH);
  localparam int LINE_IDX_W = ADDR_W - 5;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t             state, state_next;
  logic [7:0]         cnt, cnt_next;
  logic               req_write;
  logic [IDX_W-1:0]   req_idx;
  logic [LINE_W-1:0]  req_data;
  logic               req_oor;
  logic               in_oor;
  logic               accept;
  logic               commit;
  logic               op_write;
  logic [IDX_W-1:0]   op_idx;
  logic [LINE_W-1:0]  op_data;
  logic               op_oor;
  logic               unused_addr;

  logic [LINE_W-1:0]  mem [DEPTH];

`ifdef LINE_MEMORY_ADDR_CHECK_EN
  assign in_oor = addr_i[ADDR_W-1:5] >= LINE_IDX_W'(DEPTH);
`else
  assign in_oor = 1'b0;
`endif

  // Byte offset (and, without the range check, the index bits above IDX_W) carry no information.
  assign unused_addr = ^addr_i;

  assign accept = (state == S_IDLE) && enable_i;

  // With LATENCY=1 the array access happens on the acceptance edge itself, straight from the inputs.
  assign commit   = rst_i && (((state == S_WAIT) && (cnt == 8'd1)) || (accept && (LATENCY == 1)));
  assign op_write = (state == S_IDLE) ? write_i           : req_write;
  assign op_idx   = (state == S_IDLE) ? addr_i[5 +: IDX_W] : req_idx;
  assign op_data  = (state == S_IDLE) ? data_i            : req_data;
  assign op_oor   = (state == S_IDLE) ? in_oor            : req_oor;

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      S_IDLE: begin
        if (enable_i) begin
          state_next = (LATENCY == 1) ? S_ACK : S_WAIT;
          cnt_next   = 8'(LATENCY - 1);
        end
      end
      S_WAIT: begin
        cnt_next = cnt - 8'd1;
        if (cnt == 8'd1) state_next = S_ACK;
      end
      S_ACK:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= S_IDLE;
      cnt       <= '0;
      req_write <= 1'b0;
      req_idx   <= '0;
      req_data  <= '0;
      req_oor   <= 1'b0;
      data_o    <= '0;
      err_o     <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (accept) begin
        req_write <= write_i;
        req_idx   <= addr_i[5 +: IDX_W];
        req_data  <= data_i;
        req_oor   <= in_oor;
        if (in_oor) err_o <= 1'b1;
      end
      if (commit && !op_write) data_o <= op_oor ? '0 : mem[op_idx];
    end
  end

  // NOTE: the array has no reset; its contents are preloaded externally and survive rst_i.
  always_ff @(posedge clk_i) begin
    if (commit && op_write && !op_oor) mem[op_idx] <= op_data;
  end

  assign ack_o = (state == S_ACK);

endmodule

// File: tb/tb_line_memory.sv
// Directed bench for line_memory: a scoreboard queue holds expected read data until each ack.
module tb_line_memory;

  localparam int LINE_W  = 256;
  localparam int ADDR_W  = 32;
  localparam int DEPTH   = 512;
  localparam int LATENCY = 10;

  typedef struct {
    logic              wr;
    logic [LINE_W-1:0] data;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              enable = 1'b0;
  logic              write = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [LINE_W-1:0] wdata = '0;
  logic [LINE_W-1:0] rdata;
  logic              ack;
  logic              err;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];

  line_memory #(.LINE_W(LINE_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .write_i(write),
    .addr_i(addr), .data_i(wdata), .data_o(rdata), .ack_o(ack), .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request, hold it until ack (bounded), check latency, pulse width and read data.
  task automatic request(input string tag, input logic wr, input logic [ADDR_W-1:0] a,
                         input logic [LINE_W-1:0] d, input logic [LINE_W-1:0] rexp,
                         input bit disturb);
    int   cycles;
    bit   got;
    exp_t e;
    @(negedge clk);
    enable = 1'b1;
    write  = wr;
    addr   = a;
    wdata  = d;
    sb.push_back('{wr: wr, data: rexp});
    @(posedge clk);
    cycles = 0;
    got    = 1'b0;
    while (!got && cycles < 300) begin
      @(negedge clk);
      cycles++;
      if (disturb && cycles == 3) begin
        addr  = 32'h200;
        wdata = '1;
      end
      if (ack) got = 1'b1;
    end
    check({tag, "_latency"}, LINE_W'(cycles), LINE_W'(LATENCY));
    if (got && sb.size() > 0) begin
      e = sb.pop_front();
      if (!e.wr) check({tag, "_rdata"}, rdata, e.data);
    end
    enable = 1'b0;
    @(negedge clk);
    check({tag, "_ack_width"}, LINE_W'(ack), '0);
  endtask

  logic [LINE_W-1:0] pat_a5, pat_wr, pat_7, pat_12, pat_16, pat_2, pat_0, rd_before;

  initial begin
    pat_a5 = {32{8'hA5}};
    pat_wr = {4{64'h0123456789ABCDEF}};
    pat_7  = {8{32'h7777_0007}};
    pat_12 = {8{32'hC0DE_0012}};
    pat_16 = {8{32'h1616_BEEF}};
    pat_2  = {8{32'h2222_F00D}};
    pat_0  = {8{32'h0000_CAFE}};

    // 1. reset, then idle
    repeat (3) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_ack", LINE_W'(ack), '0);
      check("idle_err", LINE_W'(err), '0);
    end
    check("idle_data", rdata, '0);

    dut.mem[4]  = pat_a5;
    dut.mem[7]  = pat_7;
    dut.mem[12] = pat_12;
    dut.mem[16] = pat_16;
    dut.mem[2]  = pat_2;
    dut.mem[0]  = pat_0;

    // 2. read latency
    request("read_line4", 1'b0, 32'h80, '0, pat_a5, 1'b0);

    // 3. write then read; data_o holds across the write
    rd_before = rdata;
    request("write_line8", 1'b1, 32'h100, pat_wr, '0, 1'b0);
    check("data_hold_after_write", rdata, pat_a5);
    request("read_line8", 1'b0, 32'h100, '0, pat_wr, 1'b0);
    check("line7_untouched", dut.mem[7], pat_7);

    // 4. inputs disturbed mid-request
    request("write_disturbed", 1'b1, 32'h180, ~pat_12, '0, 1'b1);
    check("line12_written", dut.mem[12], ~pat_12);
    check("line16_untouched", dut.mem[16], pat_16);
    request("read_line12", 1'b0, 32'h180, '0, ~pat_12, 1'b0);

    // 5. reset during WAIT aborts the write
    @(negedge clk);
    enable = 1'b1;
    write  = 1'b1;
    addr   = 32'h40;
    wdata  = ~pat_2;
    @(posedge clk);
    repeat (5) begin
      @(negedge clk);
      check("abort_wait_ack", LINE_W'(ack), '0);
    end
    rst = 1'b0;
    #1;
    check("abort_rst_ack", LINE_W'(ack), '0);
    check("abort_rst_data", rdata, '0);
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      check("abort_after_ack", LINE_W'(ack), '0);
    end
    check("abort_line2_kept", dut.mem[2], pat_2);
    request("read_line2", 1'b0, 32'h40, '0, pat_2, 1'b0);
    check("err_before_oor", LINE_W'(err), '0);

    // 6. out-of-range line index
`ifdef LINE_MEMORY_ADDR_CHECK_EN
    request("read_oor", 1'b0, 32'h4000, '0, '0, 1'b0);
    check("oor_err", LINE_W'(err), LINE_W'(1));
    request("write_oor", 1'b1, 32'h4000, '1, '0, 1'b0);
    check("oor_line0_kept", dut.mem[0], pat_0);
    repeat (5) @(negedge clk);
    check("oor_err_sticky", LINE_W'(err), LINE_W'(1));
`else
    request("read_wrap", 1'b0, 32'h4000, '0, pat_0, 1'b0);
    check("wrap_err", LINE_W'(err), '0);
    repeat (5) @(negedge clk);
    check("wrap_err_idle", LINE_W'(err), '0);
`endif
    check("scoreboard_empty", LINE_W'(sb.size()), '0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/line_memory.md
Name: line_memory

Overview:
- Off-chip data memory model that sits directly downstream of the data-cache controller.
- Serves whole 256-bit cache lines through the mem_enable / mem_write / mem_addr / mem_data / mem_ack handshake.
- Each request completes after a fixed, parameterised latency.
- The testbench instantiates it beside the CPU top so cache refills and write-backs see realistic miss penalties.

Parameters:
- LINE_W, 256, line width in bits.
- ADDR_W, 32, byte-address width.
- DEPTH, 512, number of lines stored; must be a power of two.
- LATENCY, 10, cycles from request acceptance to ack; legal range 1..255.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- enable_i  input  1  request valid, held by the cache until ack.
- write_i  input  1  1 = line write-back, 0 = line read (refill).
- addr_i  input  ADDR_W  byte address; line index = addr_i[ADDR_W-1:5].
- data_i  input  LINE_W  write line data.
- data_o  output  LINE_W  read line data, valid while ack_o=1 for a read.
- ack_o  output  1  one-cycle completion pulse.
- err_o  output  1  sticky out-of-range flag (see Optional Feature).

Behaviour:
- Reset (rst_i=0, asynchronous):
  - state=IDLE, counter=0, ack_o=0, data_o=0, err_o=0, latched request cleared.
  - Array contents are not reset; the bench preloads them hierarchically.
- States: IDLE, WAIT, ACK.
- IDLE:
  - On an edge with enable_i=1, latch write_i, line index and data_i, load counter=LATENCY-1, go to WAIT.
  - If LATENCY=1, go straight to ACK instead.
  - enable_i=0: stay in IDLE.
- WAIT:
  - Decrement counter each edge; enable_i, addr_i, data_i and write_i are ignored (latched copies are used).
  - When counter=1 at an edge, go to ACK.
  - At that same edge: a write commits the latched data to the array; a read loads data_o from the array.
- ACK:
  - ack_o=1 for exactly this one cycle, then unconditionally return to IDLE.
  - A request is never accepted in ACK. The cache drops enable_i after seeing ack; if enable_i is still high in the following IDLE cycle, that is a new request.
- Latency: request sampled at edge E; ack_o is high in the cycle after edge E+LATENCY-1, i.e. exactly LATENCY cycles after acceptance.
- data_o holds its last read value until the next read completes; writes do not change data_o.
- Read-after-write to the same line returns the newly written data, since the write committed before its ack.
- Reset in WAIT aborts the request:
  - no array write occurs;
  - ack_o stays 0;
  - the requester must reissue after reset.
- Line index width is log2(DEPTH). Byte-offset bits addr_i[4:0] are ignored.

Optional Feature:
- Macro: LINE_MEMORY_ADDR_CHECK_EN.
- Defined:
  - A request whose line index addr_i[ADDR_W-1:5] >= DEPTH is still accepted and acked with normal latency.
  - A write to such an address does not modify the array.
  - A read returns all zeros on data_o.
  - err_o is set at acceptance and stays 1 until reset.
- Not defined:
  - The line index is truncated to its low log2(DEPTH) bits, so addresses wrap modulo DEPTH.
  - err_o is tied to 0.

Test Plan:
1. Reset then idle: rst_i=0 for 3 cycles, then release with enable_i=0 for 20 cycles -> ack_o=0, data_o=0, err_o=0 throughout.
2. Read latency: preload line 4 with 256'hA5..A5; enable_i=1, write_i=0, addr_i=32'h80 held until ack -> ack_o high exactly 10 cycles after acceptance, for one cycle, with data_o=256'hA5..A5.
3. Write then read: write 256'h0123..CDEF to addr 32'h100, ack, drop enable, then read 32'h100 -> second ack returns 256'h0123..CDEF; line 7 is unchanged.
4. Input changes mid-request: during WAIT change addr_i to 32'h200 and data_i to all ones -> the write lands at the original line only; line 16 is unchanged.
5. Reset abort: issue a write to 32'h40, assert rst_i=0 at cycle 5 of WAIT -> no ack, line 2 keeps its preload value, state returns to IDLE.
6. Out-of-range address: read addr 32'h4000 (line 512) with DEPTH=512 -> with the macro: ack after 10 cycles, data_o=0, err_o=1 sticky; without the macro: returns line 0 contents, err_o=0.
